// File: rtl/trng_uart_streamer.sv
// Captures TRNG words into a small FIFO and streams them MSB-first to the UART,
// one ASCII '0'/'1' per bit, stopping after TOTAL_BITS characters.
module trng_uart_streamer #(
  parameter int WORD_WIDTH = 8,
  parameter int TOTAL_BITS = 1000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        sample_valid,
  input  logic [WORD_WIDTH-1:0]       sample_word,
  input  logic                        tx_busy,
  output logic [7:0]                  uart_din,
  output logic                        uart_wr_en,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  // state    | meaning
  // C_IDLE   | waiting for start
  // C_RUN    | capturing and sending until TOTAL_BITS characters are out
  // C_FINISH | one-cycle done pulse
  // S_IDLE   | sender waiting for a word
  // S_LOAD   | pop a word into the shift register
  // S_ISSUE  | uart_wr_en high for the current bit
  // S_WAIT   | guard cycle, then wait for tx_busy low

  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;
  localparam int BS_W         = $clog2(TOTAL_BITS + 1);
  localparam int WORDS_NEEDED = (TOTAL_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WC_W         = $clog2(WORDS_NEEDED + 1);
  localparam int BL_W         = $clog2(WORD_WIDTH + 1);

  localparam logic [BS_W-1:0]  TOTAL_C    = BS_W'(TOTAL_BITS);
  localparam logic [WC_W-1:0]  WORDS_C    = WC_W'(WORDS_NEEDED);
  localparam logic [LVL_W-1:0] DEPTH_C    = LVL_W'(FIFO_DEPTH);
  localparam logic [BL_W-1:0]  WIDTH_C    = BL_W'(WORD_WIDTH);
  localparam logic [7:0]       ASCII_ONE  = 8'h31;
  localparam logic [7:0]       ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {C_IDLE, C_RUN, C_FINISH} ctl_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} snd_state_t;

  ctl_state_t ctl_state, ctl_next;
  snd_state_t snd_state, snd_next;

  logic [WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [WC_W-1:0]       words_captured;
  logic [BS_W-1:0]       bits_sent, bits_sent_inc, bits_remaining;
  logic [BL_W-1:0]       bits_left, load_len;
  logic [WORD_WIDTH-1:0] shift_reg, shift_next, fifo_head;
  logic                  wait_guard;
  logic                  start_accept;
  logic                  fifo_empty, fifo_full;
  logic                  capture_ok, push, drop, pop, advance;

  assign fifo_empty     = (level == '0);
  assign fifo_full      = (level == DEPTH_C);
  assign fifo_head      = fifo_mem[rd_ptr];
  assign capture_ok     = (ctl_state == C_RUN) && sample_valid && (words_captured < WORDS_C);
  assign push           = capture_ok && !fifo_full;
  assign drop           = capture_ok && fifo_full;
  assign bits_sent_inc  = bits_sent + 1'b1;
  assign bits_remaining = TOTAL_C - bits_sent;
  // A trailing partial word only carries its top bits_remaining MSBs.
  assign load_len       = (int'(bits_remaining) < WORD_WIDTH) ? BL_W'(bits_remaining) : WIDTH_C;
  assign shift_next     = shift_reg << 1;

  assign busy       = (ctl_state != C_IDLE);
  assign done       = (ctl_state == C_FINISH);
  assign fifo_level = level;

  always_comb begin
    ctl_next     = ctl_state;
    start_accept = 1'b0;
    case (ctl_state)
      C_IDLE: begin
        if (start) begin
          ctl_next     = C_RUN;
          start_accept = 1'b1;
        end
      end
      C_RUN:    if (bits_sent == TOTAL_C) ctl_next = C_FINISH;
      C_FINISH: ctl_next = C_IDLE;
      default:  ctl_next = C_IDLE;
    endcase
  end

  always_comb begin
    snd_next = snd_state;
    pop      = 1'b0;
    advance  = 1'b0;
    case (snd_state)
      S_IDLE:  if ((ctl_state == C_RUN) && !fifo_empty) snd_next = S_LOAD;
      S_LOAD: begin
        pop      = 1'b1;
        snd_next = S_ISSUE;
      end
      S_ISSUE: snd_next = S_WAIT;
      S_WAIT: begin
        // tx_busy is ignored in the guard cycle so the UART has time to raise it.
        if (!wait_guard && !tx_busy) begin
          advance = 1'b1;
          if (bits_left > BL_W'(1))          snd_next = S_ISSUE;
          else if (bits_sent_inc == TOTAL_C) snd_next = S_IDLE;
          else if (!fifo_empty)              snd_next = S_LOAD;
          else                               snd_next = S_IDLE;
        end
      end
      default: snd_next = S_IDLE;
    endcase
    if (start_accept) begin
      snd_next = S_IDLE;
      pop      = 1'b0;
      advance  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctl_state <= C_IDLE;
      snd_state <= S_IDLE;
    end else begin
      ctl_state <= ctl_next;
      snd_state <= snd_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= sample_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      words_captured <= '0;
      bits_sent      <= '0;
      bits_left      <= '0;
      shift_reg      <= '0;
      wait_guard     <= 1'b0;
      overflow       <= 1'b0;
      uart_wr_en     <= 1'b0;
      uart_din       <= ASCII_ZERO;
    end else if (start_accept) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      words_captured <= '0;
      bits_sent      <= '0;
      wait_guard     <= 1'b0;
      overflow       <= 1'b0;
      uart_wr_en     <= 1'b0;
    end else begin
      wait_guard <= (snd_state == S_ISSUE);
      uart_wr_en <= (snd_next == S_ISSUE);

      if (push) begin
        wr_ptr         <= wr_ptr + 1'b1;
        words_captured <= words_captured + 1'b1;
      end
      if (drop) overflow <= 1'b1;

      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      // uart_din is registered alongside the wr_en strobe and held until the next issue.
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        shift_reg <= fifo_head;
        bits_left <= load_len;
        uart_din  <= fifo_head[WORD_WIDTH-1] ? ASCII_ONE : ASCII_ZERO;
      end else if (advance) begin
        bits_sent <= bits_sent_inc;
        shift_reg <= shift_next;
        bits_left <= bits_left - 1'b1;
        if (snd_next == S_ISSUE)
          uart_din <= shift_next[WORD_WIDTH-1] ? ASCII_ONE : ASCII_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_trng_uart_streamer.sv
// Scoreboard bench for trng_uart_streamer: accepted words expand into expected
// ASCII characters; a monitor pops and compares on every uart_wr_en.
module tb_trng_uart_streamer;
  localparam int W     = 8;
  localparam int TOTAL = 60;
  localparam int DEPTH = 4;
  localparam int WORDS = (TOTAL + W - 1) / W;

  logic                     clock = 1'b0;
  logic                     reset, start, sample_valid, tx_busy;
  logic [W-1:0]             sample_word;
  logic [7:0]               uart_din;
  logic                     uart_wr_en, busy, done, overflow;
  logic [$clog2(DEPTH):0]   fifo_level;

  trng_uart_streamer #(.WORD_WIDTH(W), .TOTAL_BITS(TOTAL), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
    .sample_word(sample_word), .tx_busy(tx_busy), .uart_din(uart_din),
    .uart_wr_en(uart_wr_en), .busy(busy), .done(done), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #10 clock = ~clock;

  int          vectors = 0, miscompares = 0;
  logic [7:0]  exp_q[$];
  int          chars_run = 0, enq_run = 0, accepted = 0, done_cnt = 0;
  bit          run_active = 0, force_busy = 0, exp_ovf = 0;
  longint      cyc = 0, last_wr_cyc = -1;
  int          uart_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Words already popped by the sender = words whose first character has appeared.
  function automatic int occupancy();
    return accepted - (chars_run + W - 1) / W;
  endfunction

  task automatic drive_sample(input logic [W-1:0] w);
    sample_valid = 1'b1;
    sample_word  = w;
    if (run_active && accepted < WORDS) begin
      if (occupancy() < DEPTH) begin
        accepted++;
        for (int b = W - 1; b >= 0; b--)
          if (enq_run < TOTAL) begin
            exp_q.push_back(w[b] ? 8'h31 : 8'h30);
            enq_run++;
          end
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // UART model: busy for a random few cycles after each write.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset)           uart_cnt = 0;
      else if (uart_wr_en) uart_cnt = $urandom_range(1, 5);
      else if (uart_cnt > 0) uart_cnt--;
      tx_busy = force_busy || (uart_cnt > 0);
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clock);
      if (uart_wr_en) begin
        if (last_wr_cyc >= 0) chk("wr_gap_ge3", 32'(cyc - last_wr_cyc >= 3), 1);
        last_wr_cyc = cyc;
        chk("wr_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("uart_din", 32'(uart_din), 32'(exp_q.pop_front()));
        chars_run++;
      end
      if (done) begin
        done_cnt++;
        chk("done_char_count", chars_run, TOTAL);
        chk("done_queue_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic start_run();
    @(negedge clock);
    sample_valid = 1'b0;
    start        = 1'b1;
    run_active   = 1'b1;
    accepted     = 0;
    enq_run      = 0;
    chars_run    = 0;
    exp_ovf      = 1'b0;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("overflow_cleared", 32'(overflow), 0);
  endtask

  task automatic feed_until_quota(input int budget, input bit mid_start);
    int n = 0;
    while (accepted < WORDS && n < budget) begin
      @(negedge clock);
      sample_valid = 1'b0;
      start        = 1'b0;
      if (mid_start && n == 20) start = 1'b1;
      else if ($urandom_range(0, 2) == 0 && occupancy() < DEPTH) drive_sample(W'($urandom));
      n++;
    end
    @(negedge clock);
    sample_valid = 1'b0;
    start        = 1'b0;
    chk("quota_reached", accepted, WORDS);
  endtask

  task automatic extra_samples();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive_sample(W'($urandom));
    end
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("done_pulses", done_cnt - d0, 1);
    run_active = 1'b0;
    @(negedge clock);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, seen, wr_after;
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0; sample_word = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_wr_en", 32'(uart_wr_en), 0);
    chk("rst_din", 32'(uart_din), 32'h30);
    chk("rst_level", 32'(fifo_level), 0);
    reset = 1'b0;

    // Sample before any start is ignored.
    @(negedge clock);
    drive_sample(8'h5A);
    @(negedge clock);
    sample_valid = 1'b0;
    chk("idle_sample_level", 32'(fifo_level), 0);

    // Run 1: A5 first, push coinciding with the first pop, mid-run start, extra samples.
    start_run();
    drive_sample(8'hA5);
    @(negedge clock);
    sample_valid = 1'b0;
    @(negedge clock);
    drive_sample(8'h0F);
    @(negedge clock);
    sample_valid = 1'b0;
    chk("push_pop_level", 32'(fifo_level), 1);
    chk("first_wr_latency", 32'(uart_wr_en), 1);
    feed_until_quota(3000, 1'b1);
    extra_samples();
    wait_done(3000);
    chk("run1_overflow", 32'(overflow), 32'(exp_ovf));

    // Run 2: overflow with the UART held busy.
    start_run();
    force_busy = 1'b1;
    drive_sample(W'($urandom));
    n = 0;
    while (chars_run < 1 && n < 20) begin
      @(negedge clock);
      sample_valid = 1'b0;
      n++;
    end
    chk("ovf_first_char", chars_run, 1);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("ovf_level", 32'(fifo_level), occupancy());
      chk("ovf_flag", 32'(overflow), 32'(exp_ovf));
      drive_sample(W'($urandom));
    end
    @(negedge clock);
    sample_valid = 1'b0;
    chk("ovf_level_end", 32'(fifo_level), occupancy());
    chk("ovf_flag_end", 32'(overflow), 32'(exp_ovf));
    force_busy = 1'b0;
    feed_until_quota(3000, 1'b0);
    wait_done(3000);
    chk("ovf_sticky", 32'(overflow), 32'(exp_ovf));

    // Run 3: restart clears overflow, then reset in the wait after the 3rd character.
    start_run();
    seen = 0;
    n    = 0;
    while (seen < 3 && n < 600) begin
      @(negedge clock);
      sample_valid = 1'b0;
      if (uart_wr_en) seen++;
      else if ($urandom_range(0, 1) == 0 && occupancy() < DEPTH) drive_sample(W'($urandom));
      n++;
    end
    chk("third_char_seen", seen, 3);
    @(negedge clock);
    sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wr_en", 32'(uart_wr_en), 0);
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    chk("midrst_din", 32'(uart_din), 32'h30);
    reset      = 1'b0;
    run_active = 1'b0;
    exp_q.delete();
    wr_after = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (uart_wr_en) wr_after++;
      drive_sample(W'($urandom));
    end
    @(negedge clock);
    sample_valid = 1'b0;
    chk("no_wr_after_reset", wr_after, 0);

    // Run 4: full run after a mid-run reset.
    start_run();
    feed_until_quota(3000, 1'b0);
    wait_done(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
